// File: rtl/pwm_pkg.sv
// Shared types and constants for the SPI-driven PWM controller.
package pwm_pkg;

   // Capture FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_APPLY  = 2'd3
   } cap_state_t;

   // Opcodes with bit7 set; anything else with bit7 set is rejected
   localparam logic [7:0] OP_DISABLE = 8'h80;
   localparam logic [7:0] OP_ENABLE  = 8'h81;

   // Width of the duty field carried in a command and in the status byte
   localparam int DUTY_W = 7;

   // Limit a requested duty to the number of steps in a period
   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] req,
                                                     input int steps);
      logic [DUTY_W-1:0] res;
      res = req;
      if (int'(req) > steps) begin
         res = steps[DUTY_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM generator: prescaler, step counter, period-boundary load of the
// shadow settings into the active settings, and the registered compare.
module pwm_core
   import pwm_pkg::*;
#(
   parameter int PRESCALE = 500,
   parameter int STEPS    = 100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] shadow_duty,
   input  logic              shadow_enable,
   output logic              pwm_out,
   output logic [DUTY_W-1:0] duty_active,
   output logic              enable_active
);

   localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int CMP_W  = (STEP_W > DUTY_W) ? STEP_W + 1 : DUTY_W + 1;

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

   logic [PRE_W-1:0]  presc_reg;
   logic [STEP_W-1:0] step_reg;
   logic [DUTY_W-1:0] duty_active_reg;
   logic              enable_active_reg;
   logic              pwm_reg;
   logic              tick;
   logic              wrap;

   assign tick = (presc_reg == PRE_LAST);
   assign wrap = tick && (step_reg == STEP_LAST);

   // Prescaler: free-running 0..PRESCALE-1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_reg <= '0;
      end else if (tick) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_reg + PRE_W'(1);
      end
   end

   // Step counter: advances once per tick, wraps at STEPS-1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_reg <= '0;
      end else if (tick) begin
         if (step_reg == STEP_LAST) begin
            step_reg <= '0;
         end else begin
            step_reg <= step_reg + STEP_W'(1);
         end
      end
   end

   // Active settings change only at the period wrap, so no runt pulses;
   // a shadow written on the wrap edge itself is picked up one period later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         duty_active_reg   <= '0;
         enable_active_reg <= 1'b0;
      end else if (wrap) begin
         duty_active_reg   <= shadow_duty;
         enable_active_reg <= shadow_enable;
      end
   end

   // Registered compare; duty 0 gives constant low, duty >= STEPS constant high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_reg <= 1'b0;
      end else begin
         pwm_reg <= enable_active_reg && (CMP_W'(step_reg) < CMP_W'(duty_active_reg));
      end
   end

   assign pwm_out       = pwm_reg;
   assign duty_active   = duty_active_reg;
   assign enable_active = enable_active_reg;

endmodule

// File: rtl/pwm_controller.sv
// SPI command front end: synchronizes ss, detects end of transaction,
// double-samples the received byte, decodes it into shadow settings and
// reports the active settings back as the status byte.
module pwm_controller
   import pwm_pkg::*;
#(
   parameter int PRESCALE = 500,
   parameter int STEPS    = 100,
   parameter int SETTLE   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ss,
   input  logic [7:0] data_received,
   output logic [7:0] data_to_send,
   output logic       pwm_out,
   output logic       cmd_valid,
   output logic       cmd_err
);

   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

   logic              ss_meta_reg;
   logic              ss_sync_reg;
   logic              ss_prev_reg;
   logic              ss_rise;

   cap_state_t        state_reg, state_next;
   logic [SET_W-1:0]  cnt_reg, cnt_next;
   logic [7:0]        sample_a_reg, sample_a_next;
   logic [7:0]        sample_b_reg, sample_b_next;
   logic [DUTY_W-1:0] sh_duty_reg, sh_duty_next;
   logic              sh_enable_reg, sh_enable_next;
   logic              valid_reg, valid_next;
   logic              err_reg, err_next;

   logic [DUTY_W-1:0] duty_active;
   logic              enable_active;

   // Two-flop synchronizer plus edge history; ss idles high, so these reset
   // high to avoid a false end-of-transaction edge right after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ss_meta_reg <= 1'b1;
         ss_sync_reg <= 1'b1;
         ss_prev_reg <= 1'b1;
      end else begin
         ss_meta_reg <= ss;
         ss_sync_reg <= ss_meta_reg;
         ss_prev_reg <= ss_sync_reg;
      end
   end

   assign ss_rise = ss_sync_reg && !ss_prev_reg;

   // Capture FSM and command state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         sample_a_reg  <= '0;
         sample_b_reg  <= '0;
         sh_duty_reg   <= '0;
         sh_enable_reg <= 1'b0;
         valid_reg     <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         sample_a_reg  <= sample_a_next;
         sample_b_reg  <= sample_b_next;
         sh_duty_reg   <= sh_duty_next;
         sh_enable_reg <= sh_enable_next;
         valid_reg     <= valid_next;
         err_reg       <= err_next;
      end
   end

   // Next-state, sampling and decode; A and B are compared from registers
   // in APPLY so the async byte never feeds comparison logic directly
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      sample_a_next  = sample_a_reg;
      sample_b_next  = sample_b_reg;
      sh_duty_next   = sh_duty_reg;
      sh_enable_next = sh_enable_reg;
      valid_next     = 1'b0;
      err_next       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (ss_rise) begin
               state_next = ST_SETTLE;
               cnt_next   = SETTLE_LAST;
            end
         end

         ST_SETTLE: begin
            if (!ss_sync_reg) begin
               state_next = ST_IDLE;
            end else if (cnt_reg == '0) begin
               sample_a_next = data_received;
               cnt_next      = SETTLE_LAST;
               state_next    = ST_CHECK;
            end else begin
               cnt_next = cnt_reg - SET_W'(1);
            end
         end

         ST_CHECK: begin
            if (cnt_reg == '0) begin
               sample_b_next = data_received;
               state_next    = ST_APPLY;
            end else begin
               cnt_next = cnt_reg - SET_W'(1);
            end
         end

         ST_APPLY: begin
            state_next = ST_IDLE;
            if (sample_a_reg != sample_b_reg) begin
               err_next = 1'b1;
            end else if (!sample_a_reg[7]) begin
               sh_duty_next = clamp_duty(sample_a_reg[DUTY_W-1:0], STEPS);
               valid_next   = 1'b1;
            end else if (sample_a_reg == OP_ENABLE) begin
               sh_enable_next = 1'b1;
               valid_next     = 1'b1;
            end else if (sample_a_reg == OP_DISABLE) begin
               sh_enable_next = 1'b0;
               valid_next     = 1'b1;
            end else begin
               err_next = 1'b1;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   pwm_core #(
      .PRESCALE (PRESCALE),
      .STEPS    (STEPS)
   ) u_core (
      .clk           (clk),
      .rst           (rst),
      .shadow_duty   (sh_duty_reg),
      .shadow_enable (sh_enable_reg),
      .pwm_out       (pwm_out),
      .duty_active   (duty_active),
      .enable_active (enable_active)
   );

   assign data_to_send = {enable_active, duty_active};
   assign cmd_valid    = valid_reg;
   assign cmd_err      = err_reg;

endmodule

// File: tb/tb_pwm_controller.sv
// Self-checking bench for pwm_controller: directed scenarios plus random
// commands, checked every cycle against a period-level reference model.
module tb_pwm_controller;

   localparam int PRESCALE = 2;
   localparam int STEPS    = 100;
   localparam int SETTLE   = 4;
   localparam int PERIOD   = PRESCALE * STEPS;
   // ss released after edge e -> command outcome registered at edge e+12
   localparam int CMD_LAT  = 3 + 2 * SETTLE + 1;

   logic       clk;
   logic       rst;
   logic       ss;
   logic [7:0] data_received;
   logic [7:0] data_to_send;
   logic       pwm_out;
   logic       cmd_valid;
   logic       cmd_err;

   int n_cmp;
   int n_mis;
   int cyc;

   typedef struct {
      int         edge_no;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   cmd_t pend[$];

   // model state: shadow and active settings
   int m_sh_en, m_sh_duty, m_act_en, m_act_duty;

   pwm_controller #(
      .PRESCALE (PRESCALE),
      .STEPS    (STEPS),
      .SETTLE   (SETTLE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ss            (ss),
      .data_received (data_received),
      .data_to_send  (data_to_send),
      .pwm_out       (pwm_out),
      .cmd_valid     (cmd_valid),
      .cmd_err       (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // edge counter since reset release
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // Reference model evaluated after each edge k:
   // step during edge k-1 state = ((k-1)/PRESCALE) % STEPS, actives reload
   // from the shadows at every multiple of PERIOD, commands resolve at their edge
   always @(negedge clk) begin
      int   k;
      logic e_pwm, e_valid, e_err;
      cmd_t c;
      if (!rst) begin
         m_sh_en = 0; m_sh_duty = 0; m_act_en = 0; m_act_duty = 0;
         pend.delete();
      end else if (cyc != 0) begin
         k = cyc;
         e_pwm = (m_act_en != 0) && ((((k - 1) / PRESCALE) % STEPS) < m_act_duty);
         if (k % PERIOD == 0) begin
            m_act_en   = m_sh_en;
            m_act_duty = m_sh_duty;
         end
         e_valid = 1'b0;
         e_err   = 1'b0;
         if (pend.size() > 0 && pend[0].edge_no == k) begin
            c = pend.pop_front();
            if (c.a != c.b) begin
               e_err = 1'b1;
            end else if (c.a < 8'h80) begin
               e_valid   = 1'b1;
               m_sh_duty = (int'(c.a) > STEPS) ? STEPS : int'(c.a);
            end else if (c.a == 8'h81) begin
               e_valid = 1'b1;
               m_sh_en = 1;
            end else if (c.a == 8'h80) begin
               e_valid = 1'b1;
               m_sh_en = 0;
            end else begin
               e_err = 1'b1;
            end
         end
         check("pwm_out", pwm_out, e_pwm);
         check("data_to_send", data_to_send, (m_act_en * 128) + m_act_duty);
         check("cmd_valid", cmd_valid, e_valid);
         check("cmd_err", cmd_err, e_err);
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // One SPI transaction: byte a seen at sample A, byte b at sample B
   task automatic send_cmd(input logic [7:0] a, input logic [7:0] b);
      int e;
      @(posedge clk); #1;
      ss = 1'b0;
      data_received = a;
      step(4);
      ss = 1'b1;
      e = cyc;
      pend.push_back('{edge_no: e + CMD_LAT, a: a, b: b});
      $display("txn a=0x%02h b=0x%02h at cycle %0d", a, b, e);
      step(9);
      data_received = b;
      step(6);
   endtask

   // Transaction abandoned by ss dropping during SETTLE
   task automatic send_abort(input logic [7:0] a);
      @(posedge clk); #1;
      ss = 1'b0;
      data_received = a;
      step(4);
      ss = 1'b1;
      $display("txn aborted a=0x%02h at cycle %0d", a, cyc);
      step(3);
      ss = 1'b0;
      step(16);
   endtask

   // Count high samples up to and including the next period boundary edge
   task automatic count_to_wrap(output int hi);
      hi = 0;
      for (int i = 0; i < 2 * PERIOD; i++) begin
         @(posedge clk); #1;
         hi += int'(pwm_out);
         if (cyc % PERIOD == 0) break;
      end
   endtask

   // Align to a boundary, then count high samples over one whole period
   task automatic count_period(output int hi);
      int dummy;
      count_to_wrap(dummy);
      hi = 0;
      for (int i = 0; i < PERIOD; i++) begin
         @(posedge clk); #1;
         hi += int'(pwm_out);
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      step(n);
      rst = 1'b1;
   endtask

   initial begin
      int hi;
      int s;
      logic [7:0] a, b;
      int r;

      n_cmp = 0;
      n_mis = 0;
      ss = 1'b1;
      data_received = 8'h00;
      rst = 1'b0;
      #23;
      step(3);
      rst = 1'b1;
      step(20);
      check("reset_pwm", pwm_out, 1'b0);
      check("reset_dts", data_to_send, 8'h00);

      // Scenario 1: enable, duty 50
      send_cmd(8'h81, 8'h81);
      send_cmd(8'h32, 8'h32);
      count_period(hi);
      check("s1_high_count", hi, 100);
      check("s1_dts", data_to_send, 8'hB2);

      // Scenario 5: duty 10 written early in a period running at 50
      count_to_wrap(hi);
      send_cmd(8'h0A, 8'h0A);
      s = cyc % PERIOD;
      count_to_wrap(hi);
      check("s5_current_period", hi, 100 - s);
      check("s5_dts_old", data_to_send, 8'h8A);
      count_period(hi);
      check("s5_next_period", hi, 20);

      // Scenario 2: clamp to 100, then duty 0
      send_cmd(8'h7F, 8'h7F);
      count_period(hi);
      check("s2_full_high", hi, PERIOD);
      check("s2_dts", data_to_send, 8'hE4);
      send_cmd(8'h00, 8'h00);
      count_period(hi);
      check("s2_full_low", hi, 0);

      // Scenario 3: byte changes between samples
      send_cmd(8'h20, 8'h21);
      count_period(hi);
      check("s3_dts_unchanged", data_to_send, 8'h80);

      // Scenario 4: bad opcode and aborted transaction
      send_cmd(8'h85, 8'h85);
      send_abort(8'h33);
      count_period(hi);
      check("s4_dts_unchanged", data_to_send, 8'h80);

      // Shadow write on the same edge as the period wrap
      for (int i = 0; i < 2 * PERIOD; i++) begin
         if ((cyc + 1 + 4 + CMD_LAT) % PERIOD == 0) break;
         step(1);
      end
      send_cmd(8'h19, 8'h19);
      check("wrap_keeps_old", data_to_send, 8'h80);
      count_period(hi);
      check("wrap_new_next", data_to_send, 8'h99);
      check("wrap_high_count", hi, 50);

      // Scenario 6: asynchronous reset during CHECK, mid-period
      send_cmd(8'h32, 8'h32);
      count_to_wrap(hi);
      step(20);
      ss = 1'b0;
      data_received = 8'h44;
      step(4);
      ss = 1'b1;
      step(9);
      #2;
      rst = 1'b0;
      #1;
      check("s6_pwm_async", pwm_out, 1'b0);
      check("s6_dts_async", data_to_send, 8'h00);
      check("s6_valid_async", cmd_valid, 1'b0);
      check("s6_err_async", cmd_err, 1'b0);
      @(posedge clk); #1;
      do_reset(3);
      step(30);
      check("s6_dts_after", data_to_send, 8'h00);
      send_cmd(8'h81, 8'h81);
      send_cmd(8'h32, 8'h32);
      count_period(hi);
      check("s6_high_count", hi, 100);
      check("s6_dts", data_to_send, 8'hB2);

      // Random commands against the model
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 99);
         if (r < 45) a = 8'($urandom_range(0, 127));
         else if (r < 62) a = 8'h81;
         else if (r < 70) a = 8'h80;
         else a = 8'h80 | 8'($urandom_range(2, 127));
         b = a;
         if ($urandom_range(0, 9) == 0) b = a ^ 8'($urandom_range(1, 255));
         if ($urandom_range(0, 14) == 0) send_abort(a);
         else send_cmd(a, b);
         step($urandom_range(0, 300));
      end
      step(PERIOD + 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
